// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [3:0] TXDATA_OFF  = 4'h0;
  localparam logic [3:0] STATUS_OFF  = 4'h4;
  localparam logic [3:0] BAUDDIV_OFF = 4'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // The baud counter needs at least two cycles per bit.
  function automatic logic [15:0] clamp_div(
    input logic [15:0] v
  );
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO with occupancy count.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register decode, TX FIFO and 8N1 serializer.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  output logic        sel,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    off;
  logic          wr_en, wr_tx, wr_stat, wr_baud;
  logic          push_ok, pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_cnt, cnt_nxt;
  logic          fifo_full, fifo_empty;
  logic [3:0]    cnt4;
  logic          unused_bits;

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic        tc;

  assign off     = {adr[3:2], 2'b00};
  assign sel     = (adr[31:4] == BASE_ADDR[31:4]);
  assign wr_en   = sel && mem_write;
  assign wr_tx   = wr_en && (off == TXDATA_OFF);
  assign wr_stat = wr_en && (off == STATUS_OFF);
  assign wr_baud = wr_en && (off == BAUDDIV_OFF);

  assign unused_bits = ^{write_data[31:16], adr[1:0]};

  // A full FIFO still takes a byte when the head leaves this cycle.
  assign push_ok = wr_tx && (!fifo_full || pop);
  assign cnt_nxt = fifo_cnt + CW'(push_ok) - CW'(pop);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ovf_d  = ovf_q;
    baud_d = baud_q;
    if (wr_stat) ovf_d = 1'b0;
    else if (wr_tx && !push_ok) ovf_d = 1'b1;
    if (wr_baud) baud_d = clamp_div(write_data[15:0]);
  end

  assign tc = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          div_d   = baud_q;
          cnt_d   = baud_q - 16'd1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tc) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tc) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            div_d   = baud_q;
            cnt_d   = baud_q - 16'd1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign irq_d = (cnt_nxt == '0) && (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= 16'(CLKS_PER_BIT);
      div_q   <= 16'(CLKS_PER_BIT);
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

  always_comb begin
    cnt4 = 4'(fifo_cnt);
  end

  always_comb begin
    read_data = '0;
    if (sel) begin
      unique case (1'b1)
        (off == STATUS_OFF): begin
          read_data[ST_BUSY]             = (state_q != IDLE);
          read_data[ST_FULL]             = fifo_full;
          read_data[ST_EMPTY]            = fifo_empty;
          read_data[ST_OVF]              = ovf_q;
          read_data[ST_CNT_LSB +: 4]     = cnt4;
        end
        (off == BAUDDIV_OFF): read_data[15:0] = baud_q;
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: frames decoded on tx against queued bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] write_data;
  logic        sel;
  logic [31:0] read_data;
  logic        tx;
  logic        irq_empty;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start_cyc;
    bit         gap0;
    bit         irq;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  int   wcyc  = 0;
  int   last_end = -100;
  bit   mon_en   = 1'b0;
  bit   mon_busy = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (434)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_write  (mem_write),
    .adr        (adr),
    .write_data (write_data),
    .sel        (sel),
    .read_data  (read_data),
    .tx         (tx),
    .irq_empty  (irq_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at #1 after a rising edge; store lands on the next edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr        = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    wcyc      = cyc;
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] exp);
    adr = a;
    #1;
    chk(name, read_data, exp);
  endtask

  task automatic drain(input int maxc);
    int k;
    for (k = 0; k < maxc && (q.size() != 0 || mon_busy); k++)
      @(posedge clk);
    chk("drain_done", 32'(k < maxc), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every frame must match the head of the expected queue.
  initial begin
    exp_t e;
    bit   ok;
    int   bad_k;
    int   bv;
    logic eb;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          for (int k = 0; k < 5000 && tx !== 1'b1; k++) @(negedge clk);
        end else begin
          e        = q.pop_front();
          mon_busy = 1'b1;
          if (e.start_cyc >= 0) chk("start_latency", cyc, e.start_cyc);
          if (e.gap0) chk("b2b_gap", cyc, last_end + 1);
          ok    = 1'b1;
          bad_k = -1;
          for (int k = 0; k < 10 * e.div; k++) begin
            if (k > 0) @(negedge clk);
            bv = k / e.div;
            if (bv == 0) eb = 1'b0;
            else if (bv == 9) eb = 1'b1;
            else eb = e.data[bv-1];
            if (tx !== eb && ok) begin
              ok    = 1'b0;
              bad_k = k;
            end
          end
          chk($sformatf("frame_%02h_div%0d_badcyc%0d", e.data, e.div, bad_k),
              32'(ok), 32'd1);
          last_end = cyc;
          if (e.irq) begin
            @(negedge clk);
            chk("irq_empty_after_frame", 32'(irq_empty), 32'd1);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    mem_write  = 1'b0;
    adr        = 32'h0;
    write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("tx_in_reset", 32'(tx), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a frame at the default divisor
    wr(BASE, 32'h77);
    repeat (20) @(posedge clk);
    #1;
    chk("tx_midframe_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tx_async_reset", 32'(tx), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tx_after_reset", 32'(tx), 32'd1);
    chk("irq_after_reset", 32'(irq_empty), 32'd1);
    rd("status_reset", BASE + 32'h4, 32'h0000_0004);
    rd("baud_reset", BASE + 32'h8, 32'd434);
    mon_en = 1'b1;

    // Single byte at divisor 4
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h55);
    q.push_back('{data: 8'h55, div: 4, start_cyc: wcyc + 1, gap0: 1'b0,
                  irq: 1'b1});
    repeat (5) @(posedge clk);
    #1;
    chk("irq_low_busy", 32'(irq_empty), 32'd0);
    drain(200);

    // Back-to-back frames at divisor 2
    wr(BASE + 32'h8, 32'd2);
    wr(BASE, 32'hA5);
    q.push_back('{data: 8'hA5, div: 2, start_cyc: wcyc + 1, gap0: 1'b0,
                  irq: 1'b0});
    wr(BASE, 32'h3C);
    q.push_back('{data: 8'h3C, div: 2, start_cyc: -1, gap0: 1'b1,
                  irq: 1'b1});
    rd("status_b2b", BASE + 32'h4, 32'h0000_0011);
    drain(200);

    // Overflow: six stores, five accepted
    wr(BASE + 32'h8, 32'd16);
    for (int i = 0; i < 6; i++) begin
      wr(BASE, 32'h10 + 32'(i));
      if (i < 5)
        q.push_back('{data: 8'(8'h10 + i), div: 16,
                      start_cyc: (i == 0) ? wcyc + 1 : -1,
                      gap0: (i > 0), irq: (i == 4)});
    end
    rd("status_overflow", BASE + 32'h4, 32'h0000_004B);
    wr(BASE + 32'h4, 32'h0);
    rd("status_ovf_clear", BASE + 32'h4, 32'h0000_0043);
    drain(2000);
    repeat (20) @(posedge clk);
    #1;

    // Divisor change in the middle of a frame
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'hC3);
    q.push_back('{data: 8'hC3, div: 4, start_cyc: wcyc + 1, gap0: 1'b0,
                  irq: 1'b0});
    wr(BASE, 32'h0F);
    q.push_back('{data: 8'h0F, div: 8, start_cyc: -1, gap0: 1'b1,
                  irq: 1'b1});
    repeat (10) @(posedge clk);
    #1;
    wr(BASE + 32'h8, 32'd8);
    rd("baud_readback_8", BASE + 32'h8, 32'd8);
    drain(400);
    wr(BASE + 32'h8, 32'd0);
    rd("baud_zero_clamp", BASE + 32'h8, 32'd2);
    wr(BASE + 32'h8, 32'd1);
    rd("baud_one_clamp", BASE + 32'hA, 32'd2);

    // Decode: reserved slot and out-of-window store
    wr(BASE + 32'hC, 32'hAB);
    wr(BASE + 32'h10, 32'hCD);
    rd("status_after_decode", BASE + 32'h4, 32'h0000_0004);
    adr = BASE + 32'h10;
    #1;
    chk("sel_outside", 32'(sel), 32'd0);
    chk("rdata_outside", read_data, 32'h0);
    adr = BASE + 32'hC;
    #1;
    chk("sel_reserved", 32'(sel), 32'd1);
    chk("rdata_reserved", read_data, 32'h0);
    rd("rdata_txdata", BASE, 32'h0);
    repeat (30) @(posedge clk);
    #1;
    chk("queue_empty_end", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the ARMV4 processor's data-memory bus as a responder: the core initiates loads/stores and this block answers them.
- Processor stores bytes into a small TX FIFO; a serializer shifts them out as 8N1 frames on a single `tx` line.
- Status and baud divisor registers are readable, so firmware can poll before writing.
- Instantiated beside data memory; address decode selects it when `adr[31:4] == BASE_ADDR[31:4]`.

Parameters:
- BASE_ADDR, 32'h0000_1000, 16-byte aligned base of the register window.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- CLKS_PER_BIT, 434, reset value of the baud divisor (clk cycles per UART bit).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_write  in  1  store strobe from the core, valid for one cycle.
- adr  in  32  byte address from the core (ALU result).
- write_data  in  32  store data from the core.
- sel  out  1  combinational; high when `adr` falls inside this block's window.
- read_data  out  32  combinational load data for the selected register; 0 when `sel` is low.
- tx  out  1  serial output; idle high.
- irq_empty  out  1  registered; high when the FIFO is empty and the serializer is idle.

Behaviour:
- Register map, word offsets; bits not listed read 0.
  - 0x0 TXDATA: write pushes `write_data[7:0]`; reads 0.
  - 0x4 STATUS: bit0 busy (serializer active), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count. Any write clears overflow.
  - 0x8 BAUDDIV: 16-bit R/W, reset CLKS_PER_BIT. A written value of 0 or 1 is stored as 2.
  - 0xC: reserved; reads 0, writes ignored.
- Only a write with `sel && mem_write` has effect; `adr[1:0]` is ignored.
- Reset (asynchronous, rst_n=0):
  - FIFO emptied; serializer set to IDLE.
  - `tx=1`, `irq_empty=1`, overflow=0, BAUDDIV=CLKS_PER_BIT.
  - A frame in flight is abandoned; `tx` returns high immediately.
- FIFO push/pop:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set on the next edge.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH)+1.
- Serializer FSM: IDLE → START → DATA → STOP → IDLE/START.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, latch BAUDDIV into `div_q`, go to START on the same edge.
  - START: `tx=0` for `div_q` cycles.
  - DATA: 8 bits LSB first, each held `div_q` cycles; a 3-bit bit index counts 0..7.
  - STOP: `tx=1` for `div_q` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - A BAUDDIV write mid-frame takes effect only at the next pop.
- Latency: a TXDATA write at edge N into an empty FIFO with an idle serializer makes `tx` fall after edge N+1. The frame occupies exactly 10·`div_q` cycles.
- `tx` is driven from a flop (glitch-free).
- The baud counter counts `div_q-1` down to 0 and advances the bit on 0.
- `irq_empty` is registered from next-state: (count==0 && state==IDLE).

Decomposition:
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - register offset constants `TXDATA_OFF=4'h0`, `STATUS_OFF=4'h4`, `BAUDDIV_OFF=4'h8`
  - STATUS bit-index constants.
- Sub-module `tx_fifo`: parameterized synchronous FIFO with push, pop, din, dout, count, full, empty. The top-level holds decode, registers and the serializer FSM.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-frame, then release.
  - Required: `tx=1`, STATUS reads 0x0000_0004 (empty), BAUDDIV reads CLKS_PER_BIT.
- Single byte, BAUDDIV=4: store 0x55 to TXDATA.
  - Required: `tx` falls one cycle later.
  - Bit pattern 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40 cycles total.
  - `irq_empty` returns to 1 after the stop bit.
- Back-to-back, BAUDDIV=2: store 0xA5 and 0x3C on consecutive cycles.
  - Required: two frames with no idle cycle between the stop bit and the second start bit.
  - STATUS count reads 1 during the first frame.
- Overflow, FIFO_DEPTH=4, BAUDDIV=16: store 6 bytes in consecutive cycles.
  - Required: the first pop leaves room, so 5 bytes are accepted and 1 is dropped.
  - STATUS bit3=1 and bit1=1. A write to STATUS clears bit3.
- Divisor change mid-frame: start a frame at BAUDDIV=4, write BAUDDIV=8 during DATA.
  - Required: the current frame stays at 4 cycles/bit; the next frame uses 8.
  - Writing BAUDDIV=0 reads back 2.
- Decode: store to BASE_ADDR+0xC and to BASE_ADDR+0x10.
  - Required: no FIFO change.
  - `sel=0` for +0x10, where `read_data=0`.
